// File: rtl/riscv_pkg.sv
// Shared constants and helpers for the RISC-V fetch slice.
// Holds the bubble encoding, reset PC default, opcode constants and the B-type immediate decoder.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Sign-extended branch offset; bit 0 of a B-type immediate is always zero.
    function automatic logic [31:0] b_imm(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/riscv_btfn_pred.sv
// Static backward-taken / forward-not-taken predictor for the fetch stage.
// Only elaborated when RISCV_FETCH_BTFN_EN is defined; otherwise this file is empty.
`ifdef RISCV_FETCH_BTFN_EN
module riscv_btfn_pred
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic        pred_f,
    output logic [31:0] pred_target
);

    // A negative offset means a backward branch, which is usually a loop edge.
    assign pred_f      = (instr[6:0] == OP_BRANCH) && instr[31];
    assign pred_target = pc + b_imm(instr);

endmodule
`endif

// File: rtl/riscv_fetch.sv
// IF stage: PC register, instruction memory addressing and the IF/ID pipeline register.
// Define RISCV_FETCH_BTFN_EN to enable static backward-branch prediction.
module riscv_fetch #(
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        pred_taken_d
);

    import riscv_pkg::*;

    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] pc_plus4_f;
    logic [31:0] instr_d_q, instr_d_d;
    logic [31:0] pc_d_q, pc_d_d;
    logic [31:0] pc_plus4_d_q, pc_plus4_d_d;
    logic        valid_d_q, valid_d_d;
    logic        pred_taken_d_q, pred_taken_d_d;
    logic        pred_f;

`ifdef RISCV_FETCH_BTFN_EN
    logic [31:0] pred_target;

    riscv_btfn_pred u_btfn_pred (
        .instr       (imem_rd),
        .pc          (pc_f_q),
        .pred_f      (pred_f),
        .pred_target (pred_target)
    );
`else
    assign pred_f = 1'b0;
`endif

    assign pc_plus4_f = pc_f_q + 32'd4;

    always_comb begin
        pc_f_d = pc_plus4_f;
        // A redirect must win over a stall, otherwise a stalled IF would lose the EX correction.
        if (pc_src_e) begin
            pc_f_d = pc_target_e & ~32'd3;
        end else if (stall_f) begin
            pc_f_d = pc_f_q;
`ifdef RISCV_FETCH_BTFN_EN
        end else if (pred_f) begin
            pc_f_d = pred_target;
`endif
        end
    end

    always_comb begin
        instr_d_d      = instr_d_q;
        pc_d_d         = pc_d_q;
        pc_plus4_d_d   = pc_plus4_d_q;
        valid_d_d      = valid_d_q;
        pred_taken_d_d = pred_taken_d_q;
        if (flush_d) begin
            instr_d_d      = NOP_INSTR;
            pc_d_d         = 32'd0;
            pc_plus4_d_d   = 32'd0;
            valid_d_d      = 1'b0;
            pred_taken_d_d = 1'b0;
        end else if (!stall_d) begin
            instr_d_d      = imem_rd;
            pc_d_d         = pc_f_q;
            pc_plus4_d_d   = pc_plus4_f;
            valid_d_d      = 1'b1;
            pred_taken_d_d = pred_f;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f_q         <= RESET_PC;
            instr_d_q      <= NOP_INSTR;
            pc_d_q         <= 32'd0;
            pc_plus4_d_q   <= 32'd0;
            valid_d_q      <= 1'b0;
            pred_taken_d_q <= 1'b0;
        end else begin
            pc_f_q         <= pc_f_d;
            instr_d_q      <= instr_d_d;
            pc_d_q         <= pc_d_d;
            pc_plus4_d_q   <= pc_plus4_d_d;
            valid_d_q      <= valid_d_d;
            pred_taken_d_q <= pred_taken_d_d;
        end
    end

    assign imem_addr    = pc_f_q;
    assign pc_f         = pc_f_q;
    assign instr_d      = instr_d_q;
    assign pc_d         = pc_d_q;
    assign pc_plus4_d   = pc_plus4_d_q;
    assign valid_d      = valid_d_q;
    assign pred_taken_d = pred_taken_d_q;

endmodule

// File: tb/tb_riscv_fetch.sv
// Testbench for riscv_fetch: directed scenarios followed by random control traffic,
// all compared against a cycle-level behavioural model of the fetch stage.
module tb_riscv_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_f, stall_d, flush_d, pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] imem_addr, imem_rd;
    logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d;
    logic        valid_d, pred_taken_d;

    logic [31:0] mem [64];

    int total  = 0;
    int passed = 0;

    logic [31:0] m_pc, m_instr, m_pcd, m_pc4d;
    logic        m_valid, m_pred;

    riscv_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .pc_src_e     (pc_src_e),
        .pc_target_e  (pc_target_e),
        .imem_addr    (imem_addr),
        .imem_rd      (imem_rd),
        .pc_f         (pc_f),
        .instr_d      (instr_d),
        .pc_d         (pc_d),
        .pc_plus4_d   (pc_plus4_d),
        .valid_d      (valid_d),
        .pred_taken_d (pred_taken_d)
    );

    always #5 clk = ~clk;

    assign imem_rd = mem[imem_addr[7:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc_f"},       pc_f,       m_pc);
        check({tag, ".imem_addr"},  imem_addr,  m_pc);
        check({tag, ".instr_d"},    instr_d,    m_instr);
        check({tag, ".pc_d"},       pc_d,       m_pcd);
        check({tag, ".pc_plus4_d"}, pc_plus4_d, m_pc4d);
        check({tag, ".valid_d"},    {31'd0, valid_d},      {31'd0, m_valid});
        check({tag, ".pred"},       {31'd0, pred_taken_d}, {31'd0, m_pred});
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0000_0013;
        m_pcd   = 32'h0;
        m_pc4d  = 32'h0;
        m_valid = 1'b0;
        m_pred  = 1'b0;
    endtask

    // One clock edge: the model computes what the edge should produce, then the DUT is compared.
    task automatic tick(input string tag);
        logic [31:0] w, seq, off, n_pc;
        logic        pred;
        w    = mem[m_pc[7:2]];
        seq  = m_pc + 32'd4;
`ifdef RISCV_FETCH_BTFN_EN
        pred = (w[6:0] == 7'b1100011) && w[31];
`else
        pred = 1'b0;
`endif
        off  = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        if (pc_src_e)     n_pc = {pc_target_e[31:2], 2'b00};
        else if (stall_f) n_pc = m_pc;
        else if (pred)    n_pc = m_pc + off;
        else              n_pc = seq;
        @(posedge clk);
        #1;
        if (flush_d) begin
            m_instr = 32'h0000_0013; m_pcd = 0; m_pc4d = 0; m_valid = 0; m_pred = 0;
        end else if (!stall_d) begin
            m_instr = w; m_pcd = m_pc; m_pc4d = seq; m_valid = 1; m_pred = pred;
        end
        m_pc = n_pc;
        check_all(tag);
    endtask

    task automatic set_ctl(input logic sf, input logic sd, input logic fd, input logic ps,
                           input logic [31:0] tgt);
        stall_f = sf; stall_d = sd; flush_d = fd; pc_src_e = ps; pc_target_e = tgt;
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 64; i++) mem[i] = $urandom & 32'h7FFF_FFFF;
        reset = 1'b1;
        set_ctl(0, 0, 0, 0, 32'h0);
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) tick("free");

        // Rewind to 8 for the stall scenario.
        set_ctl(0, 0, 1, 1, 32'h8);
        tick("to8");
        set_ctl(0, 0, 0, 0, 32'h0);
        set_ctl(1, 1, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            check("stall.pc8", pc_f, 32'h8);
        end
        set_ctl(0, 0, 0, 0, 32'h0);
        tick("release");
        tick("release");

        set_ctl(1, 0, 1, 1, 32'h40);
        tick("redir40");
        check("redir.pc", pc_f, 32'h40);
        check("redir.nop", instr_d, 32'h0000_0013);
        check("redir.valid", {31'd0, valid_d}, 32'd0);

        set_ctl(0, 0, 1, 1, 32'h43);
        tick("redir43");
        check("align.pc", pc_f, 32'h40);

        set_ctl(0, 0, 1, 1, 32'hFFFF_FFFC);
        tick("totop");
        set_ctl(0, 0, 0, 0, 32'h0);
        tick("wrap");
        check("wrap.pc", pc_f, 32'h0);
        check("wrap.pc4d", pc_plus4_d, 32'h0);

        mem[4] = 32'hFE00_0EE3;
        set_ctl(0, 0, 1, 1, 32'h10);
        tick("to10");
        set_ctl(0, 0, 0, 0, 32'h0);
        tick("btfn");
`ifdef RISCV_FETCH_BTFN_EN
        check("btfn.pc", pc_f, 32'hC);
        check("btfn.pred", {31'd0, pred_taken_d}, 32'd1);
`else
        check("btfn.pc", pc_f, 32'h14);
        check("btfn.pred", {31'd0, pred_taken_d}, 32'd0);
`endif

        set_ctl(0, 0, 1, 1, 32'h20);
        tick("to20");
        set_ctl(1, 1, 1, 0, 32'h0);
        tick("stall20");
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst.pc", pc_f, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        set_ctl(0, 0, 0, 0, 32'h0);
        tick("after_rst");

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                w = $urandom | 32'h8000_0000;
                w[6:0] = 7'b1100011;
                mem[$urandom_range(0, 63)] = w;
            end
            w = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FF00 | $urandom_range(0, 255))
                                            : 32'($urandom_range(0, 255));
            set_ctl($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, w);
            tick("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
